// File: rtl/serial_frame_tx_pkg.sv
// Shared line levels, FSM encoding and width helpers for the serial frame transmitter.
package serial_frame_tx_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  function automatic int frame_width(input int data_w, input int parity_en, input int stop_bits);
    return 1 + data_w + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_baud_tick_gen.sv
// Bit-period timer: tick is high on the last sr_clk cycle of every line bit while enabled.
module baud_tick_gen
  import serial_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic sr_clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: held at zero while disabled so each frame starts on a fresh period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge sr_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: one-word holding register feeding a start/data/parity/stop shifter.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              sr_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] parallel_in,
  input  logic              load,
  output logic              ready,
  output logic              bit_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int FRAME_W = frame_width(DATA_W, PARITY_EN, STOP_BITS);
  localparam int REM_W   = FRAME_W - 1;
  localparam int BCW     = cnt_width(FRAME_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_W - 1);

  tx_state_e         state_q;
  logic [DATA_W-1:0] hold_q;
  logic              hold_par_q;
  logic              hold_full_q;
  logic [REM_W-1:0]  shreg_q;
  logic [BCW-1:0]    bit_cnt_q;
  logic              bit_out_q;
  logic              busy_q;
  logic              frame_done_q;

  logic               tick_s;
  logic               accept_s;
  logic               frame_end_s;
  logic               xfer_s;
  logic               par_s;
  logic [FRAME_W-1:0] frame_s;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .sr_clk(sr_clk),
    .rst   (rst),
    .en    (state_q == ST_SHIFT),
    .tick  (tick_s)
  );

  assign par_s       = (^parallel_in) ^ (PARITY_ODD != 0);
  assign accept_s    = load && !hold_full_q;
  assign frame_end_s = (state_q == ST_SHIFT) && tick_s && (bit_cnt_q == LAST_BIT);
  assign xfer_s      = hold_full_q && ((state_q == ST_IDLE) || frame_end_s);

  // Frame image in transmit order (bit 0 leaves first), built from the held word.
  always_comb begin
    frame_s    = {FRAME_W{STOP_BIT}};
    frame_s[0] = START_BIT;
    for (int i = 0; i < DATA_W; i++) begin
      if (LSB_FIRST != 0) begin
        frame_s[1 + i] = hold_q[i];
      end else begin
        frame_s[1 + i] = hold_q[DATA_W - 1 - i];
      end
    end
    if (PARITY_EN != 0) begin
      frame_s[1 + DATA_W] = hold_par_q;
    end else begin
      frame_s[1 + DATA_W] = STOP_BIT;
    end
  end

  // Holding register: accept and transfer are exclusive since one needs it empty, the other full.
  always_ff @(posedge sr_clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_par_q  <= 1'b0;
      hold_full_q <= 1'b0;
    end else if (accept_s) begin
      hold_q      <= parallel_in;
      hold_par_q  <= par_s;
      hold_full_q <= 1'b1;
    end else if (xfer_s) begin
      hold_full_q <= 1'b0;
    end
  end

  // Line FSM; shreg_q holds the frame bits still to follow the one on bit_out.
  always_ff @(posedge sr_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= {REM_W{STOP_BIT}};
      bit_cnt_q    <= '0;
      bit_out_q    <= IDLE_LEVEL;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) begin
            shreg_q   <= frame_s[FRAME_W-1:1];
            bit_out_q <= frame_s[0];
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end else begin
            bit_out_q <= IDLE_LEVEL;
            busy_q    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (frame_end_s) begin
            frame_done_q <= 1'b1;
            if (hold_full_q) begin
              shreg_q   <= frame_s[FRAME_W-1:1];
              bit_out_q <= frame_s[0];
              bit_cnt_q <= '0;
            end else begin
              shreg_q   <= {REM_W{STOP_BIT}};
              bit_out_q <= IDLE_LEVEL;
              bit_cnt_q <= '0;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end else if (tick_s) begin
            bit_out_q <= shreg_q[0];
            shreg_q   <= {STOP_BIT, shreg_q[REM_W-1:1]};
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          bit_out_q <= IDLE_LEVEL;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = !hold_full_q;
  assign bit_out    = bit_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: a default instance and a slow MSB-first instance.
module tb_serial_frame_tx;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       sr_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic       ready0, bit_out0, busy0, frame_done0;
  logic       ready1, bit_out1, busy1, frame_done1;

  exp_t q0[$];
  exp_t q1[$];
  logic done_exp [2];
  int   done_cyc0[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_cnt0 = 0, busy_cnt1 = 0;
  int   bz_first0 = -1, bz_last0 = -1;

  always #5 sr_clk = ~sr_clk;

  serial_frame_tx dut0 (
    .sr_clk(sr_clk), .rst(rst), .parallel_in(din0), .load(load0),
    .ready(ready0), .bit_out(bit_out0), .busy(busy0), .frame_done(frame_done0)
  );

  serial_frame_tx #(
    .CLKS_PER_BIT(4), .LSB_FIRST(0)
  ) dut1 (
    .sr_clk(sr_clk), .rst(rst), .parallel_in(din1), .load(load1),
    .ready(ready1), .bit_out(bit_out1), .busy(busy1), .frame_done(frame_done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic bo, input logic bz, input logic fd);
    exp_t e;
    int   sz;
    if (fd || done_exp[id]) check($sformatf("frame_done%0d", id), {31'd0, fd}, {31'd0, done_exp[id]});
    done_exp[id] = 1'b0;
    if (fd && id == 0) done_cyc0.push_back(cyc);
    if (bz) begin
      sz = (id == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        check($sformatf("unexpected_busy%0d", id), 32'd1, 32'd0);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        check($sformatf("bit_out%0d", id), {31'd0, bo}, {31'd0, e.b});
        done_exp[id] = e.last;
      end
    end else begin
      check($sformatf("idle_level%0d", id), {31'd0, bo}, 32'd1);
    end
  endtask

  // Monitor: sample away from the active edge and compare against the queued expectations.
  always @(negedge sr_clk) begin
    cyc++;
    if (!rst) begin
      mon(0, bit_out0, busy0, frame_done0);
      mon(1, bit_out1, busy1, frame_done1);
      if (busy0) begin
        busy_cnt0++;
        if (bz_first0 < 0) bz_first0 = cyc;
        bz_last0 = cyc;
      end
      if (busy1) busy_cnt1++;
    end
  end

  task automatic push_exp(input int id, input logic [10:0] seq, input int cpb);
    exp_t e;
    for (int i = 10; i >= 0; i--) begin
      for (int r = 0; r < cpb; r++) begin
        e.b    = seq[i];
        e.last = (i == 0) && (r == cpb - 1);
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
      end
    end
  endtask

  // Offer w until accepted; seq lists the expected line bits, first bit in the MSB.
  task automatic send(input int id, input logic [7:0] w, input logic [10:0] seq, input int cpb);
    int t = 0;
    if (id == 0) begin load0 = 1'b1; din0 = w; end
    else         begin load1 = 1'b1; din1 = w; end
    while (((id == 0) ? !ready0 : !ready1) && t < 50) begin
      @(posedge sr_clk); #1;
      t++;
    end
    if (t >= 50) begin
      check("send_timeout", 32'd1, 32'd0);
    end else begin
      push_exp(id, seq, cpb);
      @(posedge sr_clk); #1;
    end
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic wait_idle(input int id, input int budget);
    int t = 0;
    while (((id == 0) ? (q0.size() > 0 || busy0) : (q1.size() > 0 || busy1)) && t < budget) begin
      @(posedge sr_clk); #1;
      t++;
    end
    if (t >= budget) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) begin @(posedge sr_clk); #1; end
  endtask

  task automatic clear_stats();
    busy_cnt0 = 0; busy_cnt1 = 0; bz_first0 = -1; bz_last0 = -1;
    done_cyc0.delete();
  endtask

  initial begin
    done_exp[0] = 1'b0;
    done_exp[1] = 1'b0;

    // 1: reset with load held high
    load0 = 1'b1; load1 = 1'b1; din0 = 8'hA5; din1 = 8'hA5;
    repeat (2) begin
      @(posedge sr_clk); #1;
      check("rst_bit_out", {31'd0, bit_out0}, 32'd1);
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_ready", {31'd0, ready0}, 32'd1);
      check("rst_frame_done", {31'd0, frame_done0}, 32'd0);
    end
    rst = 1'b0; load0 = 1'b0; load1 = 1'b0;
    repeat (3) begin @(posedge sr_clk); #1; end
    check("post_rst_ready", {31'd0, ready0}, 32'd1);
    check("post_rst_busy", {31'd0, busy0}, 32'd0);

    // 2: single frame 0xA5 with latency check
    clear_stats();
    send(0, 8'hA5, 11'b01010010101, 1);
    check("accept_busy", {31'd0, busy0}, 32'd0);
    check("accept_ready", {31'd0, ready0}, 32'd0);
    @(posedge sr_clk); #1;
    check("start_busy", {31'd0, busy0}, 32'd1);
    check("start_bit", {31'd0, bit_out0}, 32'd0);
    check("xfer_ready", {31'd0, ready0}, 32'd1);
    wait_idle(0, 100);
    check("a5_busy_cycles", busy_cnt0, 32'd11);
    check("a5_done_count", done_cyc0.size(), 32'd1);

    // 3+4: back-to-back 0x01, 0xFF; 0x55 offered while ready is low
    clear_stats();
    send(0, 8'h01, 11'b01000000011, 1);
    send(0, 8'hFF, 11'b01111111101, 1);
    load0 = 1'b1; din0 = 8'h55;
    for (int k = 0; k < 6; k++) begin
      check("ready_blocked", {31'd0, ready0}, 32'd0);
      @(posedge sr_clk); #1;
    end
    load0 = 1'b0;
    wait_idle(0, 100);
    check("b2b_busy_cycles", busy_cnt0, 32'd22);
    check("b2b_contiguous", bz_last0 - bz_first0 + 1, 32'd22);
    check("b2b_done_count", done_cyc0.size(), 32'd2);
    if (done_cyc0.size() == 2) check("b2b_done_spacing", done_cyc0[1] - done_cyc0[0], 32'd11);

    // 5: 0x80 on the 4-clock MSB-first instance
    clear_stats();
    send(1, 8'h80, 11'b01000000011, 4);
    wait_idle(1, 200);
    check("slow_busy_cycles", busy_cnt1, 32'd44);

    // 6: reset during data bit 5 of 0xC3 with 0x3C held, then resend 0x3C
    clear_stats();
    send(0, 8'hC3, 11'b01100001101, 1);
    send(0, 8'h3C, 11'b00011110001, 1);
    repeat (5) begin @(posedge sr_clk); #1; end
    rst = 1'b1;
    @(posedge sr_clk); #1;
    q0.delete();
    check("abort_bit_out", {31'd0, bit_out0}, 32'd1);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_ready", {31'd0, ready0}, 32'd1);
    check("abort_frame_done", {31'd0, frame_done0}, 32'd0);
    rst = 1'b0;
    repeat (3) begin @(posedge sr_clk); #1; end
    check("abort_no_done", done_cyc0.size(), 32'd0);
    send(0, 8'h3C, 11'b00011110001, 1);
    wait_idle(0, 100);
    check("resend_done_count", done_cyc0.size(), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
